multi_channel_pulse_gen: RTL and testbench
==========================================

// Module: multi_channel_pulse_gen
// PURPOSE
//   NUM_CH-channel programmable pulse generator on the PLL output clock.
//   Each channel has its own runtime period, pulse width, phase offset,
//   enable and invert. A common sync_start aligns all channel phases.
//   Successor to the single-channel fixed-divider tick; drives CH[] pins.
// PARAMETERS
//   NUM_CH        10    number of output channels (1..32)
//   CNT_W         32    counter / config field width
//   RST_PERIOD    4     reset period value P (period = P+1 cycles)
//   RST_WIDTH     1     reset pulse width W (cycles high)
//   RST_EN_MASK   1     reset enable bit per channel (bit i -> CH[i])
// PORTS
//   clk_100MHz  in   1                  PLL clock; all logic on posedge
//   RSTN        in   1                  async active-low reset
//   cfg_we      in   1                  config write strobe, 1-cycle, always accepted
//   cfg_ch      in   $clog2(NUM_CH)     target channel
//   cfg_sel     in   2                  0=period 1=width 2=phase 3=ctrl{[1]=invert,[0]=enable}
//   cfg_data    in   CNT_W              write data
//   sync_start  in   1                  realign all channels
//   cfg_err     out  1                  1-cycle pulse: write rejected
//   CH          out  NUM_CH             registered channel outputs
// BEHAVIOUR
//   Reset (async, immediate): CH=0, cfg_err=0, all counters 0, active and shadow
//     P=RST_PERIOD, W=RST_WIDTH, Ph=0, invert=0, enable=RST_EN_MASK[i].
//   Counter per channel: cnt counts 0..P then wraps to 0; unsigned CNT_W arithmetic.
//   Output: CH[i] <= enable ? ((cnt < W) ^ invert) : 0; one register stage, so CH
//     reflects the cnt value held before the edge. Disabled channel: CH=0 regardless of invert.
//   Shadowing: period/width/phase writes land in shadow registers; active copies
//     update only when cnt==P (wrap), on sync_start, or while channel is disabled.
//   ctrl writes (enable, invert) take effect on the next edge, unshadowed.
//   Enable 0->1: cnt loads Ph, shadow->active in the same edge.
//   Disabled channel: cnt held at Ph (active), output 0.
//   sync_start: every channel's shadow copies to active and cnt loads active Ph, same edge.
//   Write + sync_start same cycle: written value is included in the sync load.
//   Write + wrap same cycle: written value applied at that wrap.
//   Phase apply rule: if Ph > P at apply time, load Ph=0 instead (no error flag).
//   Edge values: W=0 -> always low (before invert); W>P -> always high; P=0 ->
//     cnt stays 0, output = (W>=1)^invert.
//   cfg_ch >= NUM_CH: write ignored, cfg_err=1 for exactly one cycle.
//   Reset mid-operation: all state returns to reset values asynchronously; counting
//     restarts at cnt=0 on the first edge after RSTN rises.
// STRUCTURE
//   Package pulse_gen_pkg: CFG_PERIOD/CFG_WIDTH/CFG_PHASE/CFG_CTRL cfg_sel codes,
//     ctrl bit indices.
//   Sub-module pulse_gen_channel (counter, shadow/active regs, output flop),
//     instantiated NUM_CH times in a generate loop.
//   Top holds the write decode and cfg_err generation.
// TESTING
//   1 Reset defaults: release RSTN -> CH[0] high on edge 1, then 1 cycle in every
//     5; CH[9:1]=0.
//   2 ch3: write period=9, width=5, ctrl=1 -> CH[3] 5 high / 5 low, repeating
//     every 10 cycles.
//   3 ch0 mid-period (cnt=1): write period=7 -> current period still 5 cycles;
//     next period 8 cycles.
//   4 ch1, ch2: period=3, width=1, phase 0 and 2, enabled; pulse sync_start ->
//     CH[1] high at offset 0 mod 4, CH[2] high at offset 2 mod 4.
//   5 Edge values: width=0 -> CH low; width=4 with P=3 -> CH high; invert=1 on a
//     disabled channel -> CH stays 0.
//   6 cfg_ch=12 -> cfg_err pulses 1 cycle, no config change; RSTN low mid-pulse ->
//     CH=0 immediately, test 1 sequence repeats after release.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator: config select
// codes, control-word bit positions and a channel-index width helper.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    CFG_PERIOD = 2'd0,
    CFG_WIDTH  = 2'd1,
    CFG_PHASE  = 2'd2,
    CFG_CTRL   = 2'd3
  } cfg_sel_e;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_INV_BIT = 1;

  // Width of the channel index; at least one bit even for a single channel.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse channel: shadow/active period, width and phase registers,
// free-running counter and a registered output.
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int unsigned      CNT_W      = 32,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(4),
  parameter logic [CNT_W-1:0] RST_WIDTH  = CNT_W'(1),
  parameter logic             RST_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_period,
  input  logic             wr_width,
  input  logic             wr_phase,
  input  logic             wr_ctrl,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             sync_start,
  output logic             ch_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] p_act_q, p_act_d, w_act_q, w_act_d, ph_act_q, ph_act_d;
  logic [CNT_W-1:0] p_sh_q, p_sh_d, w_sh_q, w_sh_d, ph_sh_q, ph_sh_d;
  logic             en_q, en_d, inv_q, inv_d, ch_q, ch_d;
  logic             wrap, apply;
  logic [CNT_W-1:0] ph_apply;

  // Next-state: shadow capture, active update on wrap/sync/disabled, counter, output
  always_comb begin
    p_sh_d  = wr_period ? wr_data : p_sh_q;
    w_sh_d  = wr_width  ? wr_data : w_sh_q;
    ph_sh_d = wr_phase  ? wr_data : ph_sh_q;
    en_d    = wr_ctrl   ? wr_data[CTRL_EN_BIT]  : en_q;
    inv_d   = wr_ctrl   ? wr_data[CTRL_INV_BIT] : inv_q;

    // Apply uses the _d shadows so a write coinciding with wrap/sync lands in it.
    wrap     = en_q && (cnt_q == p_act_q);
    apply    = sync_start || !en_q || wrap;
    ph_apply = (ph_sh_d > p_sh_d) ? '0 : ph_sh_d;

    p_act_d  = apply ? p_sh_d   : p_act_q;
    w_act_d  = apply ? w_sh_d   : w_act_q;
    ph_act_d = apply ? ph_apply : ph_act_q;

    if (sync_start || !en_q) begin
      cnt_d = ph_apply;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    ch_d = en_q && ((cnt_q < w_act_q) ^ inv_q);
  end

  // State registers with asynchronous reset to the power-on configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      p_act_q  <= RST_PERIOD;
      w_act_q  <= RST_WIDTH;
      ph_act_q <= '0;
      p_sh_q   <= RST_PERIOD;
      w_sh_q   <= RST_WIDTH;
      ph_sh_q  <= '0;
      en_q     <= RST_EN;
      inv_q    <= 1'b0;
      ch_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      p_act_q  <= p_act_d;
      w_act_q  <= w_act_d;
      ph_act_q <= ph_act_d;
      p_sh_q   <= p_sh_d;
      w_sh_q   <= w_sh_d;
      ph_sh_q  <= ph_sh_d;
      en_q     <= en_d;
      inv_q    <= inv_d;
      ch_q     <= ch_d;
    end
  end

  assign ch_out = ch_q;

endmodule

// File: rtl/multi_channel_pulse_gen.sv
// NUM_CH-channel programmable pulse generator: config write decode,
// cfg_err generation and the per-channel generators.
module multi_channel_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 10,
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] RST_PERIOD  = CNT_W'(4),
  parameter logic [CNT_W-1:0] RST_WIDTH   = CNT_W'(1),
  parameter logic [31:0]      RST_EN_MASK = 32'd1
) (
  input  logic                          clk_100MHz,
  input  logic                          RSTN,
  input  logic                          cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [1:0]                    cfg_sel,
  input  logic [CNT_W-1:0]              cfg_data,
  input  logic                          sync_start,
  output logic                          cfg_err,
  output logic [NUM_CH-1:0]             CH
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic ch_ok;
  logic sel_period, sel_width, sel_phase, sel_ctrl;
  logic cfg_err_q, cfg_err_d;

  // Decode the write strobe into per-field selects; reject out-of-range channels
  always_comb begin
    ch_ok      = 32'(cfg_ch) < NUM_CH;
    sel_period = 1'b0;
    sel_width  = 1'b0;
    sel_phase  = 1'b0;
    sel_ctrl   = 1'b0;
    if (cfg_we && ch_ok) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_PERIOD: sel_period = 1'b1;
        CFG_WIDTH:  sel_width  = 1'b1;
        CFG_PHASE:  sel_phase  = 1'b1;
        default:    sel_ctrl   = 1'b1;
      endcase
    end
    cfg_err_d = cfg_we && !ch_ok;
  end

  // Registered one-cycle error pulse
  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_gen_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD),
      .RST_WIDTH  (RST_WIDTH),
      .RST_EN     (RST_EN_MASK[i])
    ) u_ch (
      .clk        (clk_100MHz),
      .rst_n      (RSTN),
      .wr_period  (sel_period && (cfg_ch == CH_W'(i))),
      .wr_width   (sel_width  && (cfg_ch == CH_W'(i))),
      .wr_phase   (sel_phase  && (cfg_ch == CH_W'(i))),
      .wr_ctrl    (sel_ctrl   && (cfg_ch == CH_W'(i))),
      .wr_data    (cfg_data),
      .sync_start (sync_start),
      .ch_out     (CH[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_pulse_gen.sv
// Self-checking bench for multi_channel_pulse_gen: hand-derived waveform
// table, directed corner sequences and randomized traffic against a
// cycle-level reference model of the channel rules.
module tb_multi_channel_pulse_gen;

  localparam int unsigned NUM_CH = 10;
  localparam int unsigned CNT_W  = 32;

  logic              clk_100MHz = 1'b0;
  logic              RSTN = 1'b0;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_ch = '0;
  logic [1:0]        cfg_sel = '0;
  logic [CNT_W-1:0]  cfg_data = '0;
  logic              sync_start = 1'b0;
  logic              cfg_err;
  logic [NUM_CH-1:0] CH;

  int checks = 0;
  int passes = 0;

  multi_channel_pulse_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .RST_PERIOD  (32'd4),
    .RST_WIDTH   (32'd1),
    .RST_EN_MASK (32'd1)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .RSTN       (RSTN),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .sync_start (sync_start),
    .cfg_err    (cfg_err),
    .CH         (CH)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Reference model: per-channel configuration and position within the period
  int unsigned m_pa[NUM_CH], m_wa[NUM_CH], m_pha[NUM_CH];
  int unsigned m_ps[NUM_CH], m_ws[NUM_CH], m_phs[NUM_CH];
  int unsigned m_pos[NUM_CH];
  bit          m_en[NUM_CH], m_inv[NUM_CH];
  logic [NUM_CH-1:0] exp_ch;
  logic              exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pa[i] = 4; m_wa[i] = 1; m_pha[i] = 0;
      m_ps[i] = 4; m_ws[i] = 1; m_phs[i] = 0;
      m_pos[i] = 0; m_en[i] = (i == 0); m_inv[i] = 0;
    end
    exp_ch = '0;
    exp_err = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently driven
  task automatic model_step();
    bit new_en[NUM_CH], new_inv[NUM_CH];
    bit good;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_ch[i] = m_en[i] && ((m_pos[i] < m_wa[i]) != m_inv[i]);
      new_en[i] = m_en[i];
      new_inv[i] = m_inv[i];
    end
    good = (int'(cfg_ch) < NUM_CH);
    exp_err = cfg_we && !good;
    if (cfg_we && good) begin
      case (cfg_sel)
        2'd0: m_ps[cfg_ch] = cfg_data;
        2'd1: m_ws[cfg_ch] = cfg_data;
        2'd2: m_phs[cfg_ch] = cfg_data;
        default: begin new_en[cfg_ch] = cfg_data[0]; new_inv[cfg_ch] = cfg_data[1]; end
      endcase
    end
    for (int i = 0; i < NUM_CH; i++) begin
      bit at_end;
      at_end = m_en[i] && (m_pos[i] == m_pa[i]);
      if (sync_start || !m_en[i] || at_end) begin
        m_pa[i] = m_ps[i];
        m_wa[i] = m_ws[i];
        m_pha[i] = (m_phs[i] > m_ps[i]) ? 0 : m_phs[i];
      end
      if (sync_start || !m_en[i]) m_pos[i] = m_pha[i];
      else if (at_end) m_pos[i] = 0;
      else m_pos[i] = m_pos[i] + 1;
      m_en[i] = new_en[i];
      m_inv[i] = new_inv[i];
    end
  endtask

  // One clock edge: model update, then compare DUT against the model
  task automatic tick();
    model_step();
    @(posedge clk_100MHz);
    #1;
    chk("model_CH", 32'(CH), 32'(exp_ch));
    chk("model_cfg_err", 32'(cfg_err), 32'(exp_err));
  endtask

  task automatic cfg_write(input int unsigned ch, input logic [1:0] sel, input int unsigned data);
    cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    RSTN = 1'b0; cfg_we = 1'b0; sync_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_100MHz);
    #1;
    chk("reset_CH", 32'(CH), 32'd0);
    chk("reset_cfg_err", 32'(cfg_err), 32'd0);
    RSTN = 1'b1;
  endtask

  // Default reset behaviour: CH[0] high on edge 1 and every 5 edges after
  task automatic reset_pattern();
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("rst_ch0", 32'(CH[0]), 32'((e % 5) == 1));
      chk("rst_ch_others", 32'(CH[NUM_CH-1:1]), 32'd0);
    end
  endtask

  typedef struct {
    int unsigned ch, per, wid, ph;
    logic        en, inv;
    logic [15:0] pat;  // MSB = first edge after sync
  } row_t;
  row_t rows[9];

  initial begin
    rows[0] = '{3, 9, 5, 0, 1'b1, 1'b0, 16'b1111100000111110};
    rows[1] = '{1, 3, 1, 0, 1'b1, 1'b0, 16'b1000100010001000};
    rows[2] = '{2, 3, 1, 2, 1'b1, 1'b0, 16'b0010001000100010};
    rows[3] = '{4, 3, 0, 0, 1'b1, 1'b0, 16'b0000000000000000};
    rows[4] = '{5, 3, 4, 0, 1'b1, 1'b0, 16'b1111111111111111};
    rows[5] = '{6, 0, 0, 0, 1'b1, 1'b1, 16'b1111111111111111};
    rows[6] = '{7, 4, 2, 9, 1'b1, 1'b1, 16'b0011100111001110};
    rows[7] = '{8, 5, 3, 4, 1'b1, 1'b0, 16'b0011100011100011};
    rows[8] = '{9, 3, 1, 0, 1'b0, 1'b1, 16'b0000000000000000};

    // Reset defaults
    do_reset();
    reset_pattern();

    // Period change mid-period on ch0: current period keeps 5, next is 8
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      if (e == 2) begin
        cfg_we = 1'b1; cfg_ch = 4'd0; cfg_sel = 2'd0; cfg_data = 32'd7;
      end
      tick();
      cfg_we = 1'b0;
      chk("shadow_ch0", 32'(CH[0]), 32'(e == 1 || e == 6 || e == 14));
    end

    // Table-driven waveforms after a common sync_start
    do_reset();
    foreach (rows[r]) begin
      cfg_write(rows[r].ch, 2'd0, rows[r].per);
      cfg_write(rows[r].ch, 2'd1, rows[r].wid);
      cfg_write(rows[r].ch, 2'd2, rows[r].ph);
      cfg_write(rows[r].ch, 2'd3, {30'd0, rows[r].inv, rows[r].en});
      sync_start = 1'b1;
      tick();
      sync_start = 1'b0;
      for (int k = 0; k < 16; k++) begin
        tick();
        chk($sformatf("table_row%0d_k%0d", r, k), 32'(CH[rows[r].ch]), 32'(rows[r].pat[15-k]));
      end
    end

    // Invalid channel: one-cycle error, no configuration change
    cfg_write(12, 2'd0, 1);
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    tick();
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      cfg_we = ($urandom_range(0, 2) == 0);
      cfg_ch = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_data = (cfg_sel == 2'd3) ? $urandom_range(0, 3) : $urandom_range(0, 12);
      sync_start = ($urandom_range(0, 31) == 0);
      tick();
    end
    cfg_we = 1'b0; sync_start = 1'b0;

    // Asynchronous reset in the middle of a CH[0] pulse
    do_reset();
    tick();
    chk("pre_reset_ch0", 32'(CH[0]), 32'd1);
    #2 RSTN = 1'b0;
    #1;
    chk("async_reset_CH", 32'(CH), 32'd0);
    model_reset();
    @(posedge clk_100MHz);
    #1 RSTN = 1'b1;
    reset_pattern();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
